// File: rtl/bus_arbiter_mux.sv
// Fixed-priority shared-bus arbiter/mux: the lowest-index enabled source drives
// the bus, an idle bus optionally holds the last driven value, and multiple
// simultaneous drivers are flagged, snapshotted and counted.
module bus_arbiter_mux #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_SOURCES = 6,
    parameter int HOLD_LAST   = 1,
    parameter int CNT_WIDTH   = 8,
    localparam int IDX_W      = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_SOURCES-1:0]           i_out_en,
    input  logic [NUM_SOURCES*BUS_WIDTH-1:0] i_src_data,
    input  logic                             i_err_clr,
    output logic [BUS_WIDTH-1:0]             o_bus,
    output logic [BUS_WIDTH-1:0]             o_bus_q,
    output logic                             o_bus_valid,
    output logic [IDX_W-1:0]                 o_driver_idx,
    output logic                             o_contention,
    output logic                             o_contention_sticky,
    output logic [NUM_SOURCES-1:0]           o_contention_mask,
    output logic [CNT_WIDTH-1:0]             o_contention_cnt
);

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [BUS_WIDTH-1:0]   win_data;
    logic                   any_en;
    logic                   contention;
    logic [BUS_WIDTH-1:0]   bus;

    logic [BUS_WIDTH-1:0]   last_q,    last_d;
    logic [BUS_WIDTH-1:0]   bus_q,     bus_d;
    logic                   valid_q,   valid_d;
    logic                   sticky_q,  sticky_d;
    logic [NUM_SOURCES-1:0] mask_q,    mask_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;

    // Priority pick: scanning from the top down lets the lowest enabled index overwrite last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (i_out_en[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
                win_data  = i_src_data[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Bus value and contention detect; clearing the lowest set bit leaves a residue only if two or more enables are set.
    always_comb begin
        any_en     = |i_out_en;
        contention = (i_out_en & (i_out_en - {{(NUM_SOURCES-1){1'b0}}, 1'b1})) != '0;
        if (win_found) begin
            bus = win_data;
        end else if (HOLD_LAST != 0) begin
            bus = last_q;
        end else begin
            bus = '0;
        end
    end

    // Next-state for the hold register, bus pipeline and contention bookkeeping; a new contention beats a same-cycle clear.
    always_comb begin
        last_d   = any_en ? bus : last_q;
        bus_d    = bus;
        valid_d  = any_en;
        sticky_d = sticky_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        if (contention) begin
            sticky_d = 1'b1;
            if (!sticky_q || i_err_clr) begin
                mask_d = i_out_en;
            end
            if (i_err_clr) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (i_err_clr) begin
            sticky_d = 1'b0;
            mask_d   = '0;
            cnt_d    = '0;
        end
    end

    // State registers, all cleared immediately by reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_q   <= '0;
            bus_q    <= '0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
        end else begin
            last_q   <= last_d;
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_bus               = bus;
    assign o_bus_q             = bus_q;
    assign o_bus_valid         = valid_q;
    assign o_driver_idx        = win_idx;
    assign o_contention        = contention;
    assign o_contention_sticky = sticky_q;
    assign o_contention_mask   = mask_q;
    assign o_contention_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux: instance A uses the defaults
// (hold last value, 8-bit counter), instance B uses HOLD_LAST=0 and a 2-bit counter.
module tb_bus_arbiter_mux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  out_en;
    logic [47:0] src_data;
    logic        err_clr;

    logic [7:0] a_bus, a_bus_q, b_bus, b_bus_q;
    logic       a_valid, b_valid, a_cont, b_cont, a_sticky, b_sticky;
    logic [2:0] a_idx, b_idx;
    logic [5:0] a_mask, b_mask;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] bus_a;
        logic [7:0] bus_b;
        logic [2:0] idx;
        logic       cont;
        logic [7:0] busq_a;
        logic [7:0] busq_b;
        logic       valid;
        logic       sticky;
        logic [5:0] mask;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, one slot per instance where behaviour differs
    logic [7:0] m_last [2];
    logic [7:0] m_busq [2];
    int         m_cnt  [2];
    logic       m_valid;
    logic       m_sticky;
    logic [5:0] m_mask;
    int         cnt_max [2] = '{255, 3};
    bit         hold    [2] = '{1'b1, 1'b0};

    bus_arbiter_mux dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_out_en(out_en), .i_src_data(src_data),
        .i_err_clr(err_clr), .o_bus(a_bus), .o_bus_q(a_bus_q), .o_bus_valid(a_valid),
        .o_driver_idx(a_idx), .o_contention(a_cont), .o_contention_sticky(a_sticky),
        .o_contention_mask(a_mask), .o_contention_cnt(a_cnt)
    );

    bus_arbiter_mux #(.BUS_WIDTH(8), .NUM_SOURCES(6), .HOLD_LAST(0), .CNT_WIDTH(2)) dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_out_en(out_en), .i_src_data(src_data),
        .i_err_clr(err_clr), .o_bus(b_bus), .o_bus_q(b_bus_q), .o_bus_valid(b_valid),
        .o_driver_idx(b_idx), .o_contention(b_cont), .o_contention_sticky(b_sticky),
        .o_contention_mask(b_mask), .o_contention_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    function automatic int first_idx(input logic [5:0] en);
        for (int i = 0; i < 6; i++) if (en[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = '0;
            m_busq[i] = '0;
            m_cnt[i]  = 0;
        end
        m_valid  = 1'b0;
        m_sticky = 1'b0;
        m_mask   = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue what the DUTs must show this cycle, then advance the model past the edge
    task automatic applyStimulus(input logic [5:0] en, input logic [47:0] src,
                                 input logic clr, input logic rstn);
        exp_t e;
        int   w;
        logic [7:0] bus [2];
        bit   cont;
        out_en   = en;
        src_data = src;
        err_clr  = clr;
        reset_n  = rstn;
        if (!rstn) model_reset();
        w    = first_idx(en);
        cont = ($countones(en) > 1);
        for (int i = 0; i < 2; i++) begin
            if (w >= 0)       bus[i] = src[w*8 +: 8];
            else if (hold[i]) bus[i] = m_last[i];
            else              bus[i] = 8'h00;
        end
        e.bus_a  = bus[0];
        e.bus_b  = bus[1];
        e.idx    = (w >= 0) ? 3'(w) : 3'd0;
        e.cont   = cont;
        e.busq_a = m_busq[0];
        e.busq_b = m_busq[1];
        e.valid  = m_valid;
        e.sticky = m_sticky;
        e.mask   = m_mask;
        e.cnt_a  = 8'(m_cnt[0]);
        e.cnt_b  = 2'(m_cnt[1]);
        exp_q.push_back(e);
        if (rstn) begin
            for (int i = 0; i < 2; i++) begin
                if (en != 0) m_last[i] = bus[i];
                m_busq[i] = bus[i];
                if (cont) begin
                    if (clr)                  m_cnt[i] = 1;
                    else if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                end else if (clr) begin
                    m_cnt[i] = 0;
                end
            end
            m_valid = (en != 0);
            if (cont) begin
                if (!m_sticky || clr) m_mask = en;
                m_sticky = 1'b1;
            end else if (clr) begin
                m_sticky = 1'b0;
                m_mask   = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("a_bus",      32'(a_bus),    32'(e.bus_a));
            checkOutput("b_bus",      32'(b_bus),    32'(e.bus_b));
            checkOutput("a_idx",      32'(a_idx),    32'(e.idx));
            checkOutput("b_idx",      32'(b_idx),    32'(e.idx));
            checkOutput("a_cont",     32'(a_cont),   32'(e.cont));
            checkOutput("b_cont",     32'(b_cont),   32'(e.cont));
            checkOutput("a_bus_q",    32'(a_bus_q),  32'(e.busq_a));
            checkOutput("b_bus_q",    32'(b_bus_q),  32'(e.busq_b));
            checkOutput("a_valid",    32'(a_valid),  32'(e.valid));
            checkOutput("b_valid",    32'(b_valid),  32'(e.valid));
            checkOutput("a_sticky",   32'(a_sticky), 32'(e.sticky));
            checkOutput("b_sticky",   32'(b_sticky), 32'(e.sticky));
            checkOutput("a_mask",     32'(a_mask),   32'(e.mask));
            checkOutput("b_mask",     32'(b_mask),   32'(e.mask));
            checkOutput("a_cnt",      32'(a_cnt),    32'(e.cnt_a));
            checkOutput("b_cnt",      32'(b_cnt),    32'(e.cnt_b));
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [5:0]  en;
        logic [47:0] src;
        reset_n  = 1'b0;
        out_en   = '0;
        src_data = '0;
        err_clr  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b0);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b0);

        $display("[TB] single driver");
        applyStimulus(6'b000100, 48'h00005A0000, 1'b0, 1'b1);
        applyStimulus(6'b000100, 48'h00005A0000, 1'b0, 1'b1);

        $display("[TB] idle hold vs zero");
        applyStimulus(6'b000001, 48'h000000000033, 1'b0, 1'b1);
        applyStimulus(6'b000000, 48'hFFFFFFFFFFFF, 1'b0, 1'b1);
        applyStimulus(6'b000000, 48'h123456789ABC, 1'b0, 1'b1);

        $display("[TB] contention and mask snapshot");
        applyStimulus(6'b010010, 48'h004400001100, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(6'b000011, 48'h0000000022EE, 1'b0, 1'b1);
        applyStimulus(6'b100000, 48'hC30000000000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(6'b111111, 48'hA1B2C3D4E5F6, 1'b0, 1'b1);

        $display("[TB] clear, and clear colliding with contention");
        applyStimulus(6'b000000, 48'h0, 1'b1, 1'b1);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b1);
        applyStimulus(6'b100001, 48'h990000000077, 1'b1, 1'b1);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b1);

        $display("[TB] asynchronous reset during contention");
        applyStimulus(6'b000000, 48'h0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(6'b001100, 48'h0000BBAA0000, 1'b0, 1'b1);
        applyStimulus(6'b001100, 48'h0000BBAA0000, 1'b0, 1'b0);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b0);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b1);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       en = 6'b000000;
                1:       en = 6'(1 << $urandom_range(0, 5));
                default: en = 6'($urandom);
            endcase
            src = {16'($urandom), 32'($urandom)};
            applyStimulus(en, src, ($urandom_range(0, 7) == 0), 1'b1);
        end

        $display("[TB] long contention for counter saturation");
        applyStimulus(6'b000000, 48'h0, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) begin
            src = {16'($urandom), 32'($urandom)};
            applyStimulus(6'b000110 | 6'($urandom), src, 1'b0, 1'b1);
        end
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b1);
        applyStimulus(6'b000000, 48'h0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised successor to the shared datapath bus. Selects one of NUM_SOURCES equal-width sources onto BUS_WIDTH.
- Fixed priority: the lowest-index enabled source wins.
- Optionally holds the last driven value when no source is enabled.
- Detects and records drive contention (more than one output enable active), plus a registered copy of the bus for timing-relaxed consumers.

Parameters:
- BUS_WIDTH, 8: width of each source and of the bus.
- NUM_SOURCES, 6: number of bus drivers; legal range 2..32.
- HOLD_LAST, 1: 1 = idle bus shows the last driven value; 0 = idle bus reads 0.
- CNT_WIDTH, 8: width of the saturating contention counter.

Ports:
- i_clk  input  1  system clock; all state on the rising edge.
- i_reset_n  input  1  reset, asynchronous, active-low.
- i_out_en  input  NUM_SOURCES  per-source output enable; bit k belongs to source k.
- i_src_data  input  NUM_SOURCES*BUS_WIDTH  packed source data; source k occupies [k*BUS_WIDTH +: BUS_WIDTH]. Narrower sources are zero-extended by the caller.
- i_err_clr  input  1  clears the sticky contention state.
- o_bus  output  BUS_WIDTH  combinational bus value, same cycle as enables.
- o_bus_q  output  BUS_WIDTH  o_bus registered, 1-cycle latency.
- o_bus_valid  output  1  registered: at least one enable was active in the previous cycle.
- o_driver_idx  output  max(1,$clog2(NUM_SOURCES))  combinational winning index; 0 when idle.
- o_contention  output  1  combinational: more than one enable active this cycle.
- o_contention_sticky  output  1  registered sticky contention flag.
- o_contention_mask  output  NUM_SOURCES  i_out_en snapshot taken at the first contention since the last clear.
- o_contention_cnt  output  CNT_WIDTH  saturating count of contention cycles.

Behaviour:
- Reset: asynchronous assertion immediately zeroes all registered state. Affected outputs and registers: o_bus_q, o_bus_valid, o_contention_sticky, o_contention_mask, o_contention_cnt and the internal last_q. Deassertion is synchronous to i_clk.
- Selection: winner = lowest k with i_out_en[k]=1. o_bus = that source's data.
- Idle (no enables): o_bus = last_q if HOLD_LAST=1, else 0. o_driver_idx = 0.
- last_q: loads o_bus on every edge where any enable is active; holds otherwise. Reset value 0, so an idle bus right after reset reads 0.
- o_bus_q <= o_bus every cycle. o_bus_valid <= |i_out_en.
- Contention: o_contention = popcount(i_out_en) > 1. The bus still carries the priority winner; it never carries an OR of sources.
- Sticky state, per edge:
  - If o_contention and sticky=0: sticky <= 1, mask <= i_out_en.
  - Later contention while sticky=1 does not alter mask.
  - cnt increments on every contention cycle and saturates at all-ones with no wrap.
- i_err_clr=1 on an edge: sticky, mask and cnt clear to 0.
  - If contention occurs in the same cycle, set wins over clear: sticky <= 1, mask <= i_out_en, cnt <= 1.
- Single enable, or no enable: no change to contention state.
- Enables change freely every cycle. There is no handshake; consumers latch o_bus on their own load strobes.

Test Plan:
1. Reset, then i_out_en=6'b000100, src2=0x5A -> o_bus=0x5A and o_driver_idx=2 same cycle. Next cycle o_bus_q=0x5A, o_bus_valid=1, o_contention=0.
2. HOLD_LAST=1: drive src0=0x33 for one cycle, then enables=0 -> o_bus stays 0x33 and o_bus_valid=0. With HOLD_LAST=0 the same stimulus gives o_bus=0x00.
3. i_out_en=6'b010010, src1=0x11, src4=0x44 -> o_bus=0x11, o_contention=1. Next edge: sticky=1, mask=6'b010010, cnt=1.
4. Continue contention with enables 6'b000011 for 3 cycles -> mask stays 6'b010010, cnt=4. With CNT_WIDTH=2, 5 contention cycles -> cnt saturates at 3.
5. Assert i_err_clr alone -> sticky, mask and cnt read 0 next cycle. Assert i_err_clr together with enables 6'b100001 -> sticky=1, mask=6'b100001, cnt=1.
6. Assert i_reset_n=0 mid-cycle during contention with cnt=7 -> all registered outputs read 0 before the next clock edge. With HOLD_LAST=1 and no enables, o_bus=0.
